// File: rtl/gen3_tx_framer.sv
// Gen3 128b/130b transmit framer: arbitrates TLP/DLLP/ordered-set traffic into a 32-bit symbol
// stream with framing tokens and block sync headers. Optional macro: GEN3_TX_LEN_CHECK_EN.
module gen3_tx_framer (
  input  logic         clk,
  input  logic         rst,
  input  logic         tlp_valid,
  output logic         tlp_ready,
  input  logic [31:0]  tlp_data,
  input  logic         tlp_sop,
  input  logic         tlp_eop,
  input  logic [10:0]  tlp_len,
  input  logic [11:0]  tlp_seq,
  input  logic         tlp_nullify,
  input  logic         dllp_valid,
  output logic         dllp_ready,
  input  logic [47:0]  dllp_data,
  input  logic         os_req,
  output logic         os_ack,
  input  logic [127:0] os_data,
  output logic [31:0]  tx_data,
  output logic [1:0]   tx_sync,
  output logic         tx_blk_start,
  output logic         frame_err
);

  localparam logic [31:0] IDL_DW = 32'h0000_0000;
  localparam logic [31:0] EDB_DW = 32'hC0C0_C0C0;
  localparam logic [31:0] EDS_DW = 32'h0090_801F;

  // DRAIN discards the remainder of an aborted TLP up to its eop.
  typedef enum logic [2:0] {IDLE, STP_TX, TLP_BODY, EDB_TX, SDP1, EDS_TX, OS_BLK, DRAIN} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   idx_reg;
  logic [31:0]  tx_data_reg, tx_data_next;
  logic [1:0]   tx_sync_reg, tx_sync_next;
  logic         blk_start_reg;
  logic         tlp_ready_reg, dllp_ready_reg;
  logic         os_ack_reg, os_ack_next;
  logic         frame_err_reg, frame_err_next;
  logic [127:0] os_blk_reg, os_blk_next;
  logic [31:0]  dllp_hi_reg, dllp_hi_next;
  logic         edb_err_reg, edb_err_next;
  logic         edb_drain_reg, edb_drain_next;
  logic         len_err;
  logic [31:0]  os_dw [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_os_dw
      assign os_dw[gi] = os_blk_reg[32*gi +: 32];
    end
  endgenerate

  // FCRC = Len(x)*x^4 mod x^4+x+1 (Len MSB first); FP makes Len+FCRC even parity.
  function automatic logic [31:0] stp_token(input logic [10:0] len, input logic [11:0] seq);
    logic [3:0] fcrc;
    logic       fb;
    fcrc = 4'h0;
    for (int i = 10; i >= 0; i--) begin
      fb   = fcrc[3] ^ len[i];
      fcrc = {fcrc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return {seq[7:0], seq[11:8], fcrc, ^{len, fcrc}, len[10:4], len[3:0], 4'hF};
  endfunction

`ifdef GEN3_TX_LEN_CHECK_EN
  logic [10:0] remaining_reg, remaining_next;
  always_comb begin
    len_err = tlp_eop ? (remaining_reg != 11'd1) : (remaining_reg <= 11'd1);
  end
`else
  assign len_err = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    tx_data_next   = IDL_DW;
    frame_err_next = 1'b0;
    os_ack_next    = 1'b0;
    os_blk_next    = os_blk_reg;
    dllp_hi_next   = dllp_hi_reg;
    edb_err_next   = edb_err_reg;
    edb_drain_next = edb_drain_reg;
`ifdef GEN3_TX_LEN_CHECK_EN
    remaining_next = remaining_reg;
`endif
    case (state_reg)
      IDLE, EDS_TX: begin
        if (state_reg == EDS_TX || os_req) begin
          // EDS must be the last DW of a block; emit IDL until then.
          if (idx_reg == 2'd3) begin
            tx_data_next = EDS_DW;
            os_ack_next  = 1'b1;
            os_blk_next  = os_data;
            state_next   = OS_BLK;
          end else begin
            state_next = EDS_TX;
          end
        end else if (dllp_valid) begin
          tx_data_next = {dllp_data[15:0], 8'hAC, 8'hF0};
          dllp_hi_next = dllp_data[47:16];
          state_next   = SDP1;
        end else if (tlp_valid && tlp_sop) begin
          tx_data_next = stp_token(tlp_len, tlp_seq);
          state_next   = STP_TX;
`ifdef GEN3_TX_LEN_CHECK_EN
          remaining_next = tlp_len - 11'd1;
`endif
        end
      end
      STP_TX, TLP_BODY: begin
        if (!tlp_valid) begin
          tx_data_next   = EDB_DW;
          frame_err_next = 1'b1;
          state_next     = DRAIN;
        end else begin
          tx_data_next = tlp_data;
          state_next   = TLP_BODY;
`ifdef GEN3_TX_LEN_CHECK_EN
          remaining_next = remaining_reg - 11'd1;
`endif
          if (len_err) begin
            edb_err_next   = 1'b1;
            edb_drain_next = !tlp_eop;
            state_next     = EDB_TX;
          end else if (tlp_eop) begin
            edb_err_next   = 1'b0;
            edb_drain_next = 1'b0;
            state_next     = tlp_nullify ? EDB_TX : IDLE;
          end
        end
      end
      EDB_TX: begin
        tx_data_next   = EDB_DW;
        frame_err_next = edb_err_reg;
        state_next     = edb_drain_reg ? DRAIN : IDLE;
      end
      SDP1: begin
        tx_data_next = dllp_hi_reg;
        state_next   = IDLE;
      end
      OS_BLK: begin
        tx_data_next = os_dw[idx_reg];
        if (idx_reg == 2'd3) state_next = IDLE;
      end
      DRAIN: begin
        if (tlp_valid && tlp_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    tx_sync_next = tx_sync_reg;
    if (idx_reg == 2'd0) tx_sync_next = (state_reg == OS_BLK) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      tx_data_reg    <= IDL_DW;
      tx_sync_reg    <= 2'b10;
      blk_start_reg  <= 1'b0;
      tlp_ready_reg  <= 1'b0;
      dllp_ready_reg <= 1'b0;
      os_ack_reg     <= 1'b0;
      frame_err_reg  <= 1'b0;
      os_blk_reg     <= '0;
      dllp_hi_reg    <= '0;
      edb_err_reg    <= 1'b0;
      edb_drain_reg  <= 1'b0;
`ifdef GEN3_TX_LEN_CHECK_EN
      remaining_reg  <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_reg + 2'd1;
      tx_data_reg    <= tx_data_next;
      tx_sync_reg    <= tx_sync_next;
      blk_start_reg  <= (idx_reg == 2'd0);
      tlp_ready_reg  <= (state_next == STP_TX) || (state_next == TLP_BODY) || (state_next == DRAIN);
      dllp_ready_reg <= (state_next == SDP1);
      os_ack_reg     <= os_ack_next;
      frame_err_reg  <= frame_err_next;
      os_blk_reg     <= os_blk_next;
      dllp_hi_reg    <= dllp_hi_next;
      edb_err_reg    <= edb_err_next;
      edb_drain_reg  <= edb_drain_next;
`ifdef GEN3_TX_LEN_CHECK_EN
      remaining_reg  <= remaining_next;
`endif
    end
  end

  assign tx_data      = tx_data_reg;
  assign tx_sync      = tx_sync_reg;
  assign tx_blk_start = blk_start_reg;
  assign tlp_ready    = tlp_ready_reg;
  assign dllp_ready   = dllp_ready_reg;
  assign os_ack       = os_ack_reg;
  assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_gen3_tx_framer.sv
// Directed bench for gen3_tx_framer: idle/reset, TLP framing, nullify, DLLP priority,
// ordered-set insertion, underrun, back-to-back TLPs and (optionally) length checking.
module tb_gen3_tx_framer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tlp_valid = 1'b0, tlp_ready;
  logic [31:0]  tlp_data = '0;
  logic         tlp_sop = 1'b0, tlp_eop = 1'b0;
  logic [10:0]  tlp_len = '0;
  logic [11:0]  tlp_seq = '0;
  logic         tlp_nullify = 1'b0;
  logic         dllp_valid = 1'b0, dllp_ready;
  logic [47:0]  dllp_data = '0;
  logic         os_req = 1'b0, os_ack;
  logic [127:0] os_data = '0;
  logic [31:0]  tx_data;
  logic [1:0]   tx_sync;
  logic         tx_blk_start, frame_err;

  int nvec = 0;
  int nerr = 0;
  int tb_idx = 0;

  gen3_tx_framer dut (
    .clk(clk), .rst(rst),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
    .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .tlp_len(tlp_len), .tlp_seq(tlp_seq),
    .tlp_nullify(tlp_nullify),
    .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_data(dllp_data),
    .os_req(os_req), .os_ack(os_ack), .os_data(os_data),
    .tx_data(tx_data), .tx_sync(tx_sync), .tx_blk_start(tx_blk_start), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    tb_idx = (tb_idx + 1) % 4;
  endtask

  task automatic drive_tlp(input logic v, input logic [31:0] d, input logic s, input logic e,
                           input logic n);
    tlp_valid = v; tlp_data = d; tlp_sop = s; tlp_eop = e; tlp_nullify = n;
  endtask

  task automatic test_reset;
    tick; tick;
    nvec++;
    if (tx_data !== 32'h0 || tx_sync !== 2'b10 || tx_blk_start !== 1'b0 || tlp_ready !== 1'b0 ||
        dllp_ready !== 1'b0 || os_ack !== 1'b0 || frame_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state tx=%h sync=%b blk=%b rdy=%b%b ack=%b ferr=%b required 0/10/0/00/0/0",
               tx_data, tx_sync, tx_blk_start, tlp_ready, dllp_ready, os_ack, frame_err);
    end
    rst = 1'b1;
    tb_idx = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      nvec++;
      if (tx_data !== 32'h0 || tx_sync !== 2'b10 || tx_blk_start !== (k % 4 == 0)) begin
        nerr++;
        $display("FAIL idle_cycle%0d tx=%h sync=%b blk=%b required 00000000/10/%0b",
                 k, tx_data, tx_sync, tx_blk_start, (k % 4 == 0));
      end
    end
    $display("reset: %0d idle cycles observed", 8);
  endtask

  // len=5, seq=012, four beats; optional nullify on eop
  task automatic test_tlp(input logic nul);
    logic [31:0] beats [4];
    for (int i = 0; i < 4; i++) beats[i] = 32'hA000_0001 + 32'(i) * 32'h0101_0101;
    tlp_len = 11'd5; tlp_seq = 12'h012;
    drive_tlp(1'b1, beats[0], 1'b1, 1'b0, 1'b0);
    tick;
    nvec++;
    if (tx_data !== 32'h120F005F || tlp_ready !== 1'b1) begin
      nerr++;
      $display("FAIL tlp_stp tx=%h rdy=%b required 120f005f/1", tx_data, tlp_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive_tlp(1'b1, beats[i], i == 0, i == 3, nul && i == 3);
      tick;
      nvec++;
      if (tx_data !== beats[i] || frame_err !== 1'b0) begin
        nerr++;
        $display("FAIL tlp_beat%0d tx=%h ferr=%b required %h/0", i, tx_data, frame_err, beats[i]);
      end
    end
    drive_tlp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    if (nul) begin
      tick;
      nvec++;
      if (tx_data !== 32'hC0C0C0C0 || frame_err !== 1'b0) begin
        nerr++;
        $display("FAIL tlp_nullify_edb tx=%h ferr=%b required c0c0c0c0/0", tx_data, frame_err);
      end
    end
    tick;
    nvec++;
    if (tx_data !== 32'h0 || tlp_ready !== 1'b0) begin
      nerr++;
      $display("FAIL tlp_end_idl tx=%h rdy=%b required 00000000/0", tx_data, tlp_ready);
    end
    $display("tlp: len=5 nullify=%0b done", nul);
  endtask

  task automatic test_dllp_priority;
    dllp_valid = 1'b1; dllp_data = 48'h665544332211;
    tlp_len = 11'd5; tlp_seq = 12'h012;
    drive_tlp(1'b1, 32'hB000_0000, 1'b1, 1'b0, 1'b0);
    tick;
    nvec++;
    if (tx_data !== 32'h2211ACF0 || dllp_ready !== 1'b1 || tlp_ready !== 1'b0) begin
      nerr++;
      $display("FAIL sdp0 tx=%h drdy=%b trdy=%b required 2211acf0/1/0", tx_data, dllp_ready, tlp_ready);
    end
    tick;
    nvec++;
    if (tx_data !== 32'h66554433 || dllp_ready !== 1'b0) begin
      nerr++;
      $display("FAIL sdp1 tx=%h drdy=%b required 66554433/0", tx_data, dllp_ready);
    end
    dllp_valid = 1'b0;
    tick;
    nvec++;
    if (tx_data !== 32'h120F005F) begin
      nerr++;
      $display("FAIL sdp_then_stp tx=%h required 120f005f", tx_data);
    end
    for (int i = 0; i < 4; i++) begin
      drive_tlp(1'b1, 32'hB000_0000 + 32'(i), i == 0, i == 3, 1'b0);
      tick;
      nvec++;
      if (tx_data !== 32'hB000_0000 + 32'(i)) begin
        nerr++;
        $display("FAIL sdp_tlp_beat%0d tx=%h required %h", i, tx_data, 32'hB000_0000 + 32'(i));
      end
    end
    drive_tlp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    $display("dllp: priority over pending TLP done");
  endtask

  task automatic test_os;
    logic [31:0] dws [4];
    dws[0] = 32'h1111_1111; dws[1] = 32'h2222_2222; dws[2] = 32'h3333_3333; dws[3] = 32'h4444_4444;
    for (int k = 0; k < 4 && tb_idx != 2; k++) tick;
    os_req = 1'b1; os_data = {dws[3], dws[2], dws[1], dws[0]};
    tick;
    nvec++;
    if (tx_data !== 32'h0 || os_ack !== 1'b0) begin
      nerr++;
      $display("FAIL os_wait_idl tx=%h ack=%b required 00000000/0", tx_data, os_ack);
    end
    tick;
    nvec++;
    if (tx_data !== 32'h0090801F || os_ack !== 1'b1 || tx_sync !== 2'b10) begin
      nerr++;
      $display("FAIL os_eds tx=%h ack=%b sync=%b required 0090801f/1/10", tx_data, os_ack, tx_sync);
    end
    os_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      nvec++;
      if (tx_data !== dws[i] || tx_sync !== 2'b01 || tx_blk_start !== (i == 0) || os_ack !== 1'b0) begin
        nerr++;
        $display("FAIL os_dw%0d tx=%h sync=%b blk=%b ack=%b required %h/01/%0b/0",
                 i, tx_data, tx_sync, tx_blk_start, os_ack, dws[i], (i == 0));
      end
    end
    tick;
    nvec++;
    if (tx_data !== 32'h0 || tx_sync !== 2'b10 || tx_blk_start !== 1'b1) begin
      nerr++;
      $display("FAIL os_after tx=%h sync=%b blk=%b required 00000000/10/1", tx_data, tx_sync, tx_blk_start);
    end
    $display("os: block inserted");
  endtask

  task automatic test_underrun;
    tlp_len = 11'd5; tlp_seq = 12'h012;
    drive_tlp(1'b1, 32'hD000_0000, 1'b1, 1'b0, 1'b0);
    tick;
    tick;
    nvec++;
    if (tx_data !== 32'hD000_0000) begin
      nerr++;
      $display("FAIL underrun_beat0 tx=%h required d0000000", tx_data);
    end
    drive_tlp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    nvec++;
    if (tx_data !== 32'hC0C0C0C0 || frame_err !== 1'b1) begin
      nerr++;
      $display("FAIL underrun_edb tx=%h ferr=%b required c0c0c0c0/1", tx_data, frame_err);
    end
    drive_tlp(1'b1, 32'hD000_0001, 1'b0, 1'b0, 1'b0);
    tick;
    nvec++;
    if (tx_data !== 32'h0 || frame_err !== 1'b0 || tlp_ready !== 1'b1) begin
      nerr++;
      $display("FAIL underrun_drain tx=%h ferr=%b rdy=%b required 00000000/0/1", tx_data, frame_err, tlp_ready);
    end
    drive_tlp(1'b1, 32'hD000_0002, 1'b0, 1'b1, 1'b0);
    tick;
    drive_tlp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (tx_data !== 32'h0 || tlp_ready !== 1'b0) begin
      nerr++;
      $display("FAIL underrun_drain_end tx=%h rdy=%b required 00000000/0", tx_data, tlp_ready);
    end
    tick;
    $display("underrun: EDB and drain done");
  endtask

  // two single-beat TLPs (len=2) back to back; exercises FP=1
  task automatic test_back_to_back;
    tlp_len = 11'd2; tlp_seq = 12'hABC;
    drive_tlp(1'b1, 32'hE000_0001, 1'b1, 1'b1, 1'b0);
    tick;
    nvec++;
    if (tx_data !== 32'hBCA6802F) begin
      nerr++;
      $display("FAIL b2b_stp1 tx=%h required bca6802f", tx_data);
    end
    tick;
    nvec++;
    if (tx_data !== 32'hE000_0001) begin
      nerr++;
      $display("FAIL b2b_beat1 tx=%h required e0000001", tx_data);
    end
    tlp_seq = 12'hABD;
    drive_tlp(1'b1, 32'hE000_0002, 1'b1, 1'b1, 1'b0);
    tick;
    nvec++;
    if (tx_data !== 32'hBDA6802F) begin
      nerr++;
      $display("FAIL b2b_stp2 tx=%h required bda6802f", tx_data);
    end
    tick;
    drive_tlp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (tx_data !== 32'hE000_0002) begin
      nerr++;
      $display("FAIL b2b_beat2 tx=%h required e0000002", tx_data);
    end
    tick;
    nvec++;
    if (tx_data !== 32'h0 || frame_err !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_idl tx=%h ferr=%b required 00000000/0", tx_data, frame_err);
    end
    $display("back_to_back: two TLPs done");
  endtask

  // len=5 but eop on the third beat
  task automatic test_len_check;
    tlp_len = 11'd5; tlp_seq = 12'h012;
    drive_tlp(1'b1, 32'hF000_0000, 1'b1, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive_tlp(1'b1, 32'hF000_0000 + 32'(i), i == 0, i == 2, 1'b0);
      tick;
      nvec++;
      if (tx_data !== 32'hF000_0000 + 32'(i)) begin
        nerr++;
        $display("FAIL lenchk_beat%0d tx=%h required %h", i, tx_data, 32'hF000_0000 + 32'(i));
      end
    end
    drive_tlp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
`ifdef GEN3_TX_LEN_CHECK_EN
    nvec++;
    if (tx_data !== 32'hC0C0C0C0 || frame_err !== 1'b1) begin
      nerr++;
      $display("FAIL lenchk_edb tx=%h ferr=%b required c0c0c0c0/1", tx_data, frame_err);
    end
    tick;
`endif
    nvec++;
    if (tx_data !== 32'h0 || frame_err !== 1'b0) begin
      nerr++;
      $display("FAIL lenchk_idl tx=%h ferr=%b required 00000000/0", tx_data, frame_err);
    end
    $display("len_check: short TLP done");
  endtask

  initial begin
    test_reset;
    test_tlp(1'b0);
    test_tlp(1'b1);
    test_dllp_priority;
    test_os;
    test_underrun;
    test_back_to_back;
    test_len_check;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
